// File: rtl/unum4_norm_pkg.sv
// unum4_norm_pkg: shared constants for the unum4 normalize-and-round stage.
//   Default datapath widths, exponent range limits, saturation mantissas and
//   the rounding-mode encoding (only round-to-nearest-even exists today).
package unum4_norm_pkg;

   localparam int MAN_IN_W_DEF  = 32;
   localparam int MAN_MAX_W_DEF = 29;
   localparam int EXP_MAX_W_DEF = 16;

   // Exponent limits, held two bits wider than the exponent so the
   // pre-check value can exceed them without wrapping.
   localparam logic signed [EXP_MAX_W_DEF+1:0] EXP_POS_MAX =
      (EXP_MAX_W_DEF+2)'((2**(EXP_MAX_W_DEF-1)) - 1);
   localparam logic signed [EXP_MAX_W_DEF+1:0] EXP_NEG_MIN =
      -((EXP_MAX_W_DEF+2)'(2**(EXP_MAX_W_DEF-1)));

   // Largest-magnitude positive (0111...1) and negative (1000...0) mantissas.
   localparam logic [MAN_MAX_W_DEF-1:0] MANT_POS_SAT = {1'b0, {(MAN_MAX_W_DEF-1){1'b1}}};
   localparam logic [MAN_MAX_W_DEF-1:0] MANT_NEG_SAT = {1'b1, {(MAN_MAX_W_DEF-1){1'b0}}};

   typedef enum logic [1:0] {
      RND_RNE = 2'd0
   } rnd_mode_e;

endpackage

// File: rtl/unum4_clz.sv
// unum4_clz: combinational leading-zero counter.
//   din : W-bit input vector
//   cnt : number of zero bits above the highest set bit (W when din == 0).
//         EXTRA widens the count beyond the minimum needed.
module unum4_clz #(
   parameter  int W     = 31,
   parameter  int EXTRA = 0,
   localparam int CW    = $clog2(W+1) + EXTRA
) (
   input  logic [W-1:0]  din,
   output logic [CW-1:0] cnt
);

   // NOTE: every always_comb output gets a default before any conditional
   // assignment, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      cnt = CW'(W);
      // Scanning upward lets the highest set bit take the last assignment.
      for (int i = 0; i < W; i++) begin
         if (din[i]) cnt = CW'(W - 1 - i);
      end
   end

endmodule

// File: rtl/unum4_norm.sv
// unum4_norm: 3-stage normalize-and-round ahead of the unum4 pack unit.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : operands valid this cycle
//   exp_in     : signed exponent
//   mant_in    : signed mantissa, value = mant_in / 2^(MAN_IN_W-2)
//   done       : start delayed 3 cycles; outputs below are valid with it
//   exp_out    : normalized signed exponent
//   mant_out   : normalized mantissa, value = mant_out / 2^(MAN_MAX_W-1)
//   ovf / unf  : result saturated / flushed to zero by exponent range
module unum4_norm
   import unum4_norm_pkg::*;
#(
   parameter int MAN_IN_W  = MAN_IN_W_DEF,
   parameter int MAN_MAX_W = MAN_MAX_W_DEF,
   parameter int EXP_MAX_W = EXP_MAX_W_DEF,
   parameter int EXTRA     = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [EXP_MAX_W-1:0] exp_in,
   input  logic [MAN_IN_W-1:0]  mant_in,
   output logic                 done,
   output logic [EXP_MAX_W-1:0] exp_out,
   output logic [MAN_MAX_W-1:0] mant_out,
   output logic                 ovf,
   output logic                 unf
);

   localparam int LW = $clog2(MAN_IN_W) + EXTRA;   // lead count width
   localparam int EW = EXP_MAX_W + 2;              // no-wrap exponent width
   localparam int GW = MAN_IN_W - MAN_MAX_W - 1;   // bits below the guard bit

   localparam logic signed [EW-1:0] E_ONE = EW'(1);
   localparam logic signed [EW-1:0] E_POS = EW'((2**(EXP_MAX_W-1)) - 1);
   localparam logic signed [EW-1:0] E_NEG = -(EW'(2**(EXP_MAX_W-1)));

   localparam logic [MAN_MAX_W-1:0] POS_SAT  = {1'b0, {(MAN_MAX_W-1){1'b1}}};
   localparam logic [MAN_MAX_W-1:0] NEG_SAT  = {1'b1, {(MAN_MAX_W-1){1'b0}}};
   localparam logic [MAN_MAX_W-1:0] POS_HALF = {2'b01, {(MAN_MAX_W-2){1'b0}}};
   localparam logic [MAN_MAX_W-1:0] NEG_HALF = {2'b11, {(MAN_MAX_W-2){1'b0}}};

   localparam rnd_mode_e RND_MODE = RND_RNE;

   // ---------------- stage 1: leading sign-bit count ----------------
   logic [MAN_IN_W-2:0] clz_in;
   logic [LW-1:0]       lead;

   // Bits equal to the sign become zeros, so a zero count gives the run length.
   assign clz_in = mant_in[MAN_IN_W-2:0] ^ {(MAN_IN_W-1){mant_in[MAN_IN_W-1]}};

   unum4_clz #(.W(MAN_IN_W-1), .EXTRA(EXTRA)) u_clz (
      .din (clz_in),
      .cnt (lead)
   );

   logic                 v1, v2;
   logic [EXP_MAX_W-1:0] exp1;
   logic [MAN_IN_W-1:0]  mant1;
   logic [LW-1:0]        lead1;
   logic                 zero1;

   // ---------------- stage 2: shift and exponent adjust ----------------
   logic [MAN_IN_W-1:0]  sh;
   logic signed [EW-1:0] exp_ext, lead_ext, e_n;

   always_comb begin
      sh       = mant1 << lead1;
      exp_ext  = {{2{exp1[EXP_MAX_W-1]}}, exp1};
      lead_ext = EW'(lead1);
      e_n      = exp_ext + E_ONE - lead_ext;
   end

   logic                 zero2, sign2, g2, s2;
   logic [MAN_MAX_W-1:0] m2;
   logic signed [EW-1:0] e2;

   // NOTE: datapath registers carry no reset; only the valids and the
   // visible outputs need a defined value, and data is qualified by valid.
   always_ff @(posedge clk) begin
      exp1  <= exp_in;
      mant1 <= mant_in;
      lead1 <= lead;
      zero1 <= (mant_in == '0);
      zero2 <= zero1;
      sign2 <= sh[MAN_IN_W-1];
      m2    <= sh[MAN_IN_W-1 -: MAN_MAX_W];
      g2    <= sh[GW];
      s2    <= |sh[GW-1:0];
      e2    <= e_n;
   end

   // ---------------- stage 3: round, renormalize, range check ----------------
   logic                 inc;
   logic [MAN_MAX_W-1:0] mr, mant_n;
   logic signed [EW-1:0] er;
   logic [EXP_MAX_W-1:0] exp_n;
   logic                 ovf_n, unf_n;

   always_comb begin
      inc = 1'b0;
      if (RND_MODE == RND_RNE) inc = g2 & (s2 | m2[0]);
      mr = m2 + MAN_MAX_W'(inc);
      er = e2;
      // Rounding can only leave the normalized form at these two points.
      if (!sign2 && mr[MAN_MAX_W-1]) begin
         mr = POS_HALF;
         er = e2 + E_ONE;
      end else if (sign2 && mr == NEG_HALF) begin
         mr = NEG_SAT;
         er = e2 - E_ONE;
      end

      mant_n = mr;
      exp_n  = er[EXP_MAX_W-1:0];
      ovf_n  = 1'b0;
      unf_n  = 1'b0;
      if (zero2) begin
         mant_n = '0;
         exp_n  = '0;
      end else if (er > E_POS) begin
         ovf_n  = 1'b1;
         exp_n  = {1'b0, {(EXP_MAX_W-1){1'b1}}};
         mant_n = sign2 ? NEG_SAT : POS_SAT;
      end else if (er < E_NEG) begin
         unf_n  = 1'b1;
         mant_n = '0;
         exp_n  = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples the previous-cycle value of the stage before it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1       <= 1'b0;
         v2       <= 1'b0;
         done     <= 1'b0;
         ovf      <= 1'b0;
         unf      <= 1'b0;
         exp_out  <= '0;
         mant_out <= '0;
      end else begin
         v1   <= start;
         v2   <= v1;
         done <= v2;
         // Results hold between dones.
         if (v2) begin
            ovf      <= ovf_n;
            unf      <= unf_n;
            exp_out  <= exp_n;
            mant_out <= mant_n;
         end
      end
   end

endmodule

// File: tb/tb_unum4_norm.sv
// tb_unum4_norm: directed vectors with hand-computed results, checked by a
// cycle-accurate scoreboard (done timing, result fields, output hold).
module tb_unum4_norm;
   import unum4_norm_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start = 1'b0;
   logic [15:0] exp_in = '0;
   logic [31:0] mant_in = '0;
   logic        done, ovf, unf;
   logic [15:0] exp_out;
   logic [28:0] mant_out;

   unum4_norm #(.MAN_IN_W(32), .MAN_MAX_W(29), .EXP_MAX_W(16), .EXTRA(0)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .exp_in   (exp_in),
      .mant_in  (mant_in),
      .done     (done),
      .exp_out  (exp_out),
      .mant_out (mant_out),
      .ovf      (ovf),
      .unf      (unf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [28:0] mant;
      logic [15:0] expo;
      logic        ovf;
      logic        unf;
      int          cyc;
   } res_t;

   res_t q[$];
   res_t last;
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
   endtask

   task automatic send(input logic [31:0] m, input logic [15:0] e,
                       input logic [28:0] em, input logic [15:0] ee,
                       input logic eo, input logic eu);
      @(posedge clk); #1;
      start   = 1'b1;
      mant_in = m;
      exp_in  = e;
      q.push_back('{mant: em, expo: ee, ovf: eo, unf: eu, cyc: cyc});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
   endtask

   // Scoreboard: done must appear exactly 3 cycles after each start;
   // between dones the outputs must hold the last result.
   always @(negedge clk) begin
      logic exp_done;
      exp_done = (q.size() > 0) && (q[0].cyc + 3 == cyc);
      check("done", 64'(done), 64'(exp_done));
      if (exp_done) begin
         check("mant_out", 64'(mant_out), 64'(q[0].mant));
         check("exp_out",  64'(exp_out),  64'(q[0].expo));
         check("ovf",      64'(ovf),      64'(q[0].ovf));
         check("unf",      64'(unf),      64'(q[0].unf));
         last = q.pop_front();
      end else begin
         check("hold", {17'd0, ovf, unf, exp_out, mant_out},
                       {17'd0, last.ovf, last.unf, last.expo, last.mant});
         if (q.size() > 0 && q[0].cyc + 3 < cyc) begin
            check("lost_op", 64'(q[0].cyc + 3), 64'(cyc));
            void'(q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      last  = '{mant: '0, expo: '0, ovf: 1'b0, unf: 1'b0, cyc: 0};
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst_done", 64'(done),     64'(0));
      check("rst_mant", 64'(mant_out), 64'(0));
      check("rst_exp",  64'(exp_out),  64'(0));
      check("rst_ovf",  64'(ovf),      64'(0));
      check("rst_unf",  64'(unf),      64'(0));
      @(posedge clk); #1 rst_n = 1'b1;
      idle(2);

      // Isolated zero operand: exponent ignored.
      send(32'h0000_0000, 16'd5,    29'h0000_0000, 16'h0000, 1'b0, 1'b0);
      idle(4);

      // Back-to-back stream.
      send(32'h4000_0000, 16'd3,    29'h0800_0000, 16'h0004, 1'b0, 1'b0); // 1.0, no shift
      send(32'h0000_0001, 16'd0,    29'h0800_0000, 16'hFFE3, 1'b0, 1'b0); // tiny, -29
      send(32'h3FFF_FFFF, 16'd0,    29'h0800_0000, 16'h0001, 1'b0, 1'b0); // positive carry
      send(32'hC000_0000, 16'd0,    29'h1000_0000, 16'h0000, 1'b0, 1'b0); // -1.0
      send(32'h4000_0000, 16'h7FFF, MANT_POS_SAT,  EXP_POS_MAX[15:0], 1'b1, 1'b0);
      send(32'h0000_0001, 16'h8000, 29'h0000_0000, 16'h0000, 1'b0, 1'b1);
      send(32'h8000_0000, 16'h7FFF, MANT_NEG_SAT,  EXP_POS_MAX[15:0], 1'b1, 1'b0); // -2.0 saturates
      send(32'h4000_0004, 16'd0,    29'h0800_0000, 16'h0001, 1'b0, 1'b0); // tie, even: down
      send(32'h4000_000C, 16'd0,    29'h0800_0002, 16'h0001, 1'b0, 1'b0); // tie, odd: up
      send(32'hBFFF_FFFC, 16'd0,    29'h1000_0000, 16'h0000, 1'b0, 1'b0); // negative renorm
      send(32'h4000_0000, 16'h7FFE, 29'h0800_0000, 16'h7FFF, 1'b0, 1'b0); // exp at max
      send(32'h2000_0000, 16'h8000, 29'h0800_0000, EXP_NEG_MIN[15:0], 1'b0, 1'b0); // exp at min
      send(32'h1000_0000, 16'h8000, 29'h0000_0000, 16'h0000, 1'b0, 1'b1); // one below min
      send(32'hFFFF_FFFF, 16'd0,    29'h1000_0000, 16'hFFE2, 1'b0, 1'b0); // -tiny, lead 31
      send(32'h0000_0000, 16'h8000, 29'h0000_0000, 16'h0000, 1'b0, 1'b0); // zero beats unf
      idle(6);

      // Reset with two operations in flight.
      send(32'h4000_0000, 16'd3,    29'h0800_0000, 16'h0004, 1'b0, 1'b0);
      idle(5);
      send(32'h3FFF_FFFF, 16'd0,    29'h0800_0000, 16'h0001, 1'b0, 1'b0);
      send(32'hC000_0000, 16'd0,    29'h1000_0000, 16'h0000, 1'b0, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      rst_n = 1'b0;
      q.delete();
      last  = '{mant: '0, expo: '0, ovf: 1'b0, unf: 1'b0, cyc: 0};
      #1;
      check("mid_rst_done", 64'(done),     64'(0));
      check("mid_rst_mant", 64'(mant_out), 64'(0));
      check("mid_rst_exp",  64'(exp_out),  64'(0));
      check("mid_rst_ovf",  64'(ovf),      64'(0));
      check("mid_rst_unf",  64'(unf),      64'(0));
      @(posedge clk); #1 rst_n = 1'b1;
      idle(1);
      send(32'hC000_0000, 16'd7,    29'h1000_0000, 16'h0007, 1'b0, 1'b0);
      idle(6);

      check("drain", 64'(q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
